// File: rtl/load_store_unit_if.sv
// Bundles the request, data-memory and response signals of the load/store unit.
// "master" is the unit side; "slave" is the execute-stage / memory / writeback side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_ack, mem_err,
    output req_ready,
    output mem_addr, mem_be, mem_wdata, mem_we, mem_re,
    output rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_ack, mem_err,
    input  req_ready,
    input  mem_addr, mem_be, mem_wdata, mem_we, mem_re,
    input  rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request legality checks, lane steering, a single
// outstanding data-memory access with timeout, and registered response.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 2048,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned CW         = $clog2(TIMEOUT) + 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic          we_q;

  logic [1:0]    size;
  logic          funct3_ok;
  logic          mis_chk;
  logic          out_of_range;
  logic          illegal;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          timeout_hit;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign bus.req_ready = (state == IDLE);

  // Request decode; funct3[1:0] gives the access width, funct3[2] the unsigned flag.
  always_comb begin
    size         = bus.req_funct3[1:0];
    if (bus.req_we)
      funct3_ok  = !bus.req_funct3[2] && (size != 2'b11);
    else
      funct3_ok  = (size != 2'b11) && (bus.req_funct3 != 3'b110);
    mis_chk      = funct3_ok &&
                   (((size == 2'b01) && bus.req_addr[0]) ||
                    ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00)));
    out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    illegal      = !funct3_ok || mis_chk || out_of_range;
    case (size)
      2'b00: begin
        be    = 4'b0001 << bus.req_addr[1:0];
        wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // Counter holds the number of completed WAIT cycles; give up once it would reach TIMEOUT-1.
  assign timeout_hit = (count == CW'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.req_valid) state_next = illegal ? RESP : WAIT;
      WAIT: if (bus.mem_ack || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count              <= '0;
      funct3_q           <= '0;
      lane_q             <= '0;
      we_q               <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_be         <= '0;
      bus.mem_wdata      <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_re         <= 1'b0;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.rsp_misaligned <= 1'b0;
      bus.rsp_fault      <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q <= bus.req_funct3;
            lane_q   <= bus.req_addr[1:0];
            we_q     <= bus.req_we;
            count    <= '0;
            if (illegal) begin
              bus.rsp_valid      <= 1'b1;
              bus.rsp_rdata      <= '0;
              bus.rsp_misaligned <= mis_chk;
              bus.rsp_fault      <= !funct3_ok || out_of_range;
            end else begin
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_be    <= be;
              bus.mem_wdata <= bus.req_we ? wdata : '0;
              bus.mem_we    <= bus.req_we;
              bus.mem_re    <= !bus.req_we;
            end
          end
        end
        WAIT: begin
          count <= count + CW'(1);
          if (bus.mem_ack) begin
            bus.mem_we         <= 1'b0;
            bus.mem_re         <= 1'b0;
            bus.rsp_valid      <= 1'b1;
            bus.rsp_rdata      <= (bus.mem_err || we_q) ? '0 : load_data;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_fault      <= bus.mem_err;
          end else if (timeout_hit) begin
            bus.mem_we         <= 1'b0;
            bus.mem_re         <= 1'b0;
            bus.rsp_valid      <= 1'b1;
            bus.rsp_rdata      <= '0;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_fault      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a width/lane based reference model.
module tb_load_store_unit;
  localparam int unsigned MEM_WORDS = 2048;
  localparam int unsigned TIMEOUT   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    int        delay;
    bit        err;
    bit        withhold;
    bit [31:0] rdata;
    bit        abort;
  } txn_t;

  typedef struct {
    bit [31:0] rdata;
    bit        mis;
    bit        fault;
    int        lat;
    int        p;
  } rsp_exp_t;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    int        delay;
    bit        err;
    bit        withhold;
    bit        abort;
    bit [31:0] rdata;
  } mem_exp_t;

  rsp_exp_t rsp_q[$];
  mem_exp_t mem_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pcyc     = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic note_fail(string name);
    n_checks++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  function automatic int size_of(bit [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal_f3(bit we, bit [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  // Reference model: derives response and memory access from width, lane and range rules.
  function automatic void plan(input txn_t t, output rsp_exp_t r, output mem_exp_t m, output bit strobe);
    int        sz    = size_of(t.f3);
    int        lane  = int'(t.addr % 4);
    bit        legal = legal_f3(t.we, t.f3);
    bit        oor   = t.addr >= 4 * MEM_WORDS;
    bit [3:0]  ones  = 4'((1 << sz) - 1);
    bit [31:0] mask  = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    bit [31:0] v;
    r = '{default: 0};
    m = '{default: 0};
    r.mis   = legal && (t.addr % sz != 0);
    r.fault = !legal || oor;
    strobe  = !(r.mis || r.fault);
    if (!strobe) begin
      r.lat = 1;
      return;
    end
    m.we       = t.we;
    m.addr     = t.addr - lane;
    m.be       = ones << lane;
    for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = t.wdata[8*(i % sz) +: 8];
    m.delay    = t.delay;
    m.err      = t.err;
    m.withhold = t.withhold;
    m.abort    = t.abort;
    m.rdata    = t.rdata;
    if (t.withhold) begin
      r.lat   = TIMEOUT;
      r.fault = 1'b1;
    end else begin
      r.lat = t.delay + 1;
      if (t.err) r.fault = 1'b1;
      else if (!t.we) begin
        v = (t.rdata >> (8 * lane)) & mask;
        if (!t.f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        r.rdata = v;
      end
    end
  endfunction

  function automatic txn_t mk(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                              int delay, bit err, bit withhold, bit [31:0] rdata, bit abort);
    txn_t t;
    t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wdata; t.delay = delay;
    t.err = err; t.withhold = withhold; t.rdata = rdata; t.abort = abort;
    return t;
  endfunction

  task automatic issue(input txn_t t);
    rsp_exp_t r;
    mem_exp_t m;
    bit       strobe;
    int       waited = 0;
    plan(t, r, m, strobe);
    bus.req_valid = 1'b0;
    @(negedge clk);
    // A pending reset is released on the same edge the request is driven.
    if (!rst_n) rst_n = 1'b1;
    while (!bus.req_ready) begin
      if (waited++ > 100) begin
        note_fail("req_ready_wait");
        return;
      end
      bus.req_valid  = ($urandom_range(0, 3) == 0);
      bus.req_we     = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom_range(0, 8191);
      bus.req_wdata  = $urandom;
      @(negedge clk);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = t.we;
    bus.req_funct3 = t.f3;
    bus.req_addr   = t.addr;
    bus.req_wdata  = t.wdata;
    r.p = pcyc;
    if (strobe) mem_q.push_back(m);
    if (!t.abort) rsp_q.push_back(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) t.f3 = 3'($urandom);
    else if (t.we) t.f3 = 3'($urandom_range(0, 2));
    else begin
      case ($urandom_range(0, 4))
        0: t.f3 = 3'd0;
        1: t.f3 = 3'd1;
        2: t.f3 = 3'd2;
        3: t.f3 = 3'd4;
        default: t.f3 = 3'd5;
      endcase
    end
    if ($urandom_range(0, 7) == 0) t.addr = $urandom;
    else t.addr = $urandom_range(0, 4 * MEM_WORDS - 1);
    if ($urandom_range(0, 1) == 1) t.addr = t.addr & ~32'd3;
    t.wdata    = $urandom;
    t.delay    = $urandom_range(1, 4);
    t.err      = ($urandom_range(0, 7) == 0);
    t.withhold = ($urandom_range(0, 15) == 0);
    t.rdata    = $urandom;
    t.abort    = 1'b0;
    return t;
  endfunction

  // Memory responder: checks the strobed access against the model and acks after the planned delay.
  initial begin : responder
    mem_exp_t cur;
    bit       active = 1'b0;
    int       cnt    = 0;
    cur = '{default: 0};
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_re && bus.mem_we) note_fail("strobes_both_high");
      if (bus.mem_re || bus.mem_we) begin
        if (!active) begin
          if (mem_q.size() == 0) begin
            note_fail("unexpected_strobe");
            cur = '{default: 0};
            cur.withhold = 1'b1;
            cur.abort    = 1'b1;
          end else cur = mem_q.pop_front();
          active = 1'b1;
          cnt    = 0;
        end
        check("mem_we", 32'(bus.mem_we), 32'(cur.we));
        check("mem_re", 32'(bus.mem_re), 32'(!cur.we));
        check("mem_addr", bus.mem_addr, cur.addr);
        check("mem_be", 32'(bus.mem_be), 32'(cur.be));
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
        cnt++;
        if (!cur.withhold && cnt == cur.delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_err   = cur.err;
          bus.mem_rdata = cur.rdata;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_err   = 1'($urandom);
          bus.mem_rdata = $urandom;
        end
      end else begin
        if (active && cur.withhold && !cur.abort)
          check("timeout_strobe_cycles", 32'(cnt), 32'(TIMEOUT - 1));
        active      = 1'b0;
        bus.mem_ack = 1'b0;
      end
    end
  end

  initial begin : monitor
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) note_fail("unexpected_rsp_valid");
        else begin
          r = rsp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, r.rdata);
          check("rsp_misaligned", 32'(bus.rsp_misaligned), 32'(r.mis));
          check("rsp_fault", 32'(bus.rsp_fault), 32'(r.fault));
          check("rsp_latency", 32'(pcyc - r.p), 32'(r.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int waited;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #2;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_mem_re", 32'(bus.mem_re), 32'd0);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    check("reset_mem_be", 32'(bus.mem_be), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_flags", {30'd0, bus.rsp_misaligned, bus.rsp_fault}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(mk(1'b0, 3'b000, 32'h0000_0013, 32'h0, 1, 1'b0, 1'b0, 32'h80FF_1234, 1'b0));
    issue(mk(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 1, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b010, 32'h0000_0006, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b010, 32'h0000_2000, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b101, 32'h0000_0004, 32'h0, 1, 1'b0, 1'b1, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b010, 32'h0000_2001, 32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b000, 32'h0000_0100, 32'h0, 2, 1'b1, 1'b0, 32'h1234_5678, 1'b0));
    issue(mk(1'b1, 3'b101, 32'h0000_0010, 32'h1, 1, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(mk(1'b0, 3'b100, 32'h0000_1FFF, 32'h0, 3, 1'b0, 1'b0, 32'hA5C3_0000, 1'b0));

    for (int i = 0; i < 150; i++) issue(rand_txn());

    issue(mk(1'b0, 3'b010, 32'h0000_0040, 32'h0, 1, 1'b0, 1'b1, 32'h0, 1'b1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_mem_re", 32'(bus.mem_re), 32'd0);
    check("abort_mem_we", 32'(bus.mem_we), 32'd0);
    check("abort_mem_be", 32'(bus.mem_be), 32'd0);
    check("abort_mem_addr", bus.mem_addr, 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    issue(mk(1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'h0, 1'b0));

    waited = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (rsp_q.size() != 0 || mem_q.size() != 0) note_fail("drain_timeout");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
